// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM client-port arbiter.
// Queue entries carry a fixed 32-bit address field; the top narrows it.
package sdram_arb_pkg;

    localparam int DEFAULT_WQ_DEPTH = 4;
    localparam int ENT_AW = 32;

    typedef enum logic [1:0] {
        IDLE,
        CMD_RD,
        WAIT_RD,
        CMD_WR
    } arb_state_t;

    typedef struct packed {
        logic [ENT_AW-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        byte_en;
    } wq_entry_t;

endpackage

// File: rtl/wr_queue.sv
// Circular write FIFO with a parallel address compare over valid entries.
// A push while full succeeds only if a pop happens in the same cycle.
module wr_queue
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_WQ_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  wq_entry_t         push_data_i,
    input  logic              pop_i,
    input  logic [ENT_AW-1:0] match_addr_i,
    output wq_entry_t         head_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              match_o,
    output logic              drop_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wq_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     off;
    logic              do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && !do_push;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Entry i is live when its distance from the head is below the count.
    always_comb begin
        match_o = 1'b0;
        off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr_q;
            if (({1'b0, off} < cnt_q) &&
                (mem_q[i].addr == match_addr_i)) begin
                match_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM client port between queued shadow writes and video reads.
// Reads win unless the write queue is starved, full, or holds the read address.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int WQ_DEPTH      = DEFAULT_WQ_DEPTH,
    parameter int MAX_RD_STREAK = 3,
    parameter int ADDR_WIDTH    = 21
) (
    input  logic                  clk_logic,
    input  logic                  system_reset_n,
    input  logic                  wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [31:0]           wr_data_i,
    input  logic [3:0]            wr_byte_en_i,
    output logic                  wq_full_o,
    output logic                  wq_overflow_o,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [31:0]           rd_data_o,
    output logic                  rd_valid_o,
    output logic                  rd_busy_o,
    output logic                  sdram_rd_o,
    output logic                  sdram_wr_o,
    output logic [ADDR_WIDTH-1:0] sdram_addr_o,
    output logic [31:0]           sdram_data_o,
    output logic [3:0]            sdram_byte_en_o,
    input  logic                  sdram_ready_i,
    input  logic [31:0]           sdram_q_i,
    input  logic                  sdram_q_valid_i
);

    localparam int SW = $clog2(MAX_RD_STREAK + 2);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);

    arb_state_t            state_q, state_d;
    logic [SW-1:0]         streak_q, streak_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  ovf_q, ovf_d;

    wq_entry_t             push_ent;
    wq_entry_t             head;
    logic [ENT_AW-1:0]     match_addr;
    logic                  wq_empty, wq_full, wq_match, wq_drop;
    logic                  wq_pop, hazard, rd_blocked;
    logic                  unused_head_addr;

    assign push_ent.addr    = ENT_AW'(wr_addr_i);
    assign push_ent.data    = wr_data_i;
    assign push_ent.byte_en = wr_byte_en_i;
    assign match_addr       = ENT_AW'(raddr_q);
    assign wq_pop           = (state_q == CMD_WR) && sdram_ready_i;
    assign unused_head_addr = ^head.addr;

    wr_queue #(
        .DEPTH(WQ_DEPTH)
    ) u_wr_queue (
        .clk_i       (clk_logic),
        .rst_ni      (system_reset_n),
        .push_i      (wr_req_i),
        .push_data_i (push_ent),
        .pop_i       (wq_pop),
        .match_addr_i(match_addr),
        .head_o      (head),
        .empty_o     (wq_empty),
        .full_o      (wq_full),
        .match_o     (wq_match),
        .drop_o      (wq_drop)
    );

    // A read waiting on a queued write to the same word must let it drain.
    assign hazard     = pend_q && wq_match;
    assign rd_blocked = (!wq_empty && (streak_q == STREAK_MAX))
                      || hazard || wq_full;

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        pend_d   = pend_q;
        raddr_d  = raddr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        ovf_d    = ovf_q | wq_drop;

        if (rd_req_i && !pend_q) begin
            pend_d  = 1'b1;
            raddr_d = rd_addr_i;
        end

        unique case (state_q)
            IDLE: begin
                if (pend_q && !rd_blocked) begin
                    state_d = CMD_RD;
                end else if (!wq_empty) begin
                    state_d = CMD_WR;
                end
            end
            CMD_RD: begin
                if (sdram_ready_i) begin
                    state_d = WAIT_RD;
                    if (!wq_empty && (streak_q != STREAK_MAX)) begin
                        streak_d = streak_q + SW'(1);
                    end
                end
            end
            WAIT_RD: begin
                if (sdram_q_valid_i) begin
                    rdata_d  = sdram_q_i;
                    rvalid_d = 1'b1;
                    pend_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            CMD_WR: begin
                if (sdram_ready_i) begin
                    streak_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wq_empty) begin
            streak_d = '0;
        end
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q  <= IDLE;
            streak_q <= '0;
            pend_q   <= 1'b0;
            raddr_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            pend_q   <= pend_d;
            raddr_q  <= raddr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
        end
    end

    // Commands are a pure function of state, so they hold until accepted.
    always_comb begin
        sdram_rd_o      = 1'b0;
        sdram_wr_o      = 1'b0;
        sdram_addr_o    = '0;
        sdram_data_o    = '0;
        sdram_byte_en_o = '0;
        unique case (state_q)
            CMD_RD: begin
                sdram_rd_o   = 1'b1;
                sdram_addr_o = raddr_q;
            end
            CMD_WR: begin
                sdram_wr_o      = 1'b1;
                sdram_addr_o    = ADDR_WIDTH'(head.addr);
                sdram_data_o    = head.data;
                sdram_byte_en_o = head.byte_en;
            end
            default: ;
        endcase
    end

    assign wq_full_o     = wq_full;
    assign wq_overflow_o = ovf_q;
    assign rd_data_o     = rdata_q;
    assign rd_valid_o    = rvalid_q;
    assign rd_busy_o     = pend_q;

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares one SDRAM client port between two requesters:
  - Apple II shadow-memory writes (one byte lane per bus write).
  - Video scan-out word reads.
- Bus writes go into a small FIFO so they are never lost while video reads occupy the port.
- Video reads get priority, but queued writes have a bounded wait, and read-after-write ordering is enforced.
- Sits between the bus-shadow write logic / video fetch logic and the SDRAM controller client port.

Parameters:
- WQ_DEPTH, 4, write-queue entries (power of two, 2..16).
- MAX_RD_STREAK, 3, consecutive reads granted while the write queue is non-empty before a write is forced.
- ADDR_WIDTH, 21, SDRAM word-address width.

Ports:
- clk_logic  input  1  system logic clock.
- system_reset_n  input  1  asynchronous active-low reset.
- wr_req_i  input  1  single-cycle pulse: queue a shadow write.
- wr_addr_i  input  ADDR_WIDTH  word address of the write.
- wr_data_i  input  32  byte replicated on all lanes.
- wr_byte_en_i  input  4  one-hot lane select.
- wq_full_o  output  1  write queue full.
- wq_overflow_o  output  1  sticky: a write was dropped because the queue was full.
- rd_req_i  input  1  single-cycle pulse: request a video read.
- rd_addr_i  input  ADDR_WIDTH  word address of the read.
- rd_data_o  output  32  read word.
- rd_valid_o  output  1  one-cycle pulse; rd_data_o is valid while it is high.
- rd_busy_o  output  1  a read is pending or in flight.
- sdram_rd_o  output  1  read command.
- sdram_wr_o  output  1  write command.
- sdram_addr_o  output  ADDR_WIDTH  command address.
- sdram_data_o  output  32  write data.
- sdram_byte_en_o  output  4  write lane enables.
- sdram_ready_i  input  1  controller accepts the presented command this cycle.
- sdram_q_i  input  32  read data from the controller.
- sdram_q_valid_i  input  1  sdram_q_i is valid this cycle.

Behaviour:
- Reset: all outputs are 0 and the queue is empty.
  - Covers wq_full_o, wq_overflow_o, rd_valid_o, rd_busy_o, sdram_rd_o, sdram_wr_o, all data/address outputs, and the streak counter.
- Write queue is a circular FIFO of {addr, data, byte_en}.
  - Push on wr_req_i when not full.
  - wr_req_i while full: the entry is dropped and wq_overflow_o sets; it clears only on reset.
  - Push and pop in the same cycle while full: the pop is processed first and the push succeeds.
- Read request:
  - rd_req_i latches rd_addr_i into a single pending slot.
  - rd_req_i while rd_busy_o is high is ignored; the requester must wait.
  - rd_busy_o rises the cycle after rd_req_i.
- One SDRAM operation is outstanding at a time.
  - A command is held stable (rd/wr/addr/data/byte_en) until sdram_ready_i is sampled high; the acceptance happens on that edge.
- FSM states: IDLE, CMD_RD, WAIT_RD, CMD_WR.
- IDLE transitions:
  - Go to CMD_RD if a read is pending and none of the following hold: queue non-empty with streak == MAX_RD_STREAK; hazard active; queue full.
  - Otherwise go to CMD_WR if the queue is non-empty.
  - Otherwise stay in IDLE.
- Hazard: the pending read address equals the address of any valid queue entry (all entries are compared).
  - While the hazard is active, writes drain until it clears, so a read never returns stale data.
- CMD_RD: assert sdram_rd_o with the pending address. On ready, go to WAIT_RD and increment the streak (saturating) if the queue is non-empty.
- WAIT_RD: on sdram_q_valid_i:
  - register the data to rd_data_o and pulse rd_valid_o for the next cycle;
  - clear the pending slot and rd_busy_o in that same next cycle;
  - return to IDLE.
- CMD_WR: present the queue head. On ready, pop it, reset the streak to 0, and go to IDLE.
- Each op spends at least one cycle in IDLE, so the minimum spacing between commands is 2 cycles.
- Queue empty: the streak resets to 0.
- Pointers and count wrap modulo WQ_DEPTH. The count is clog2(WQ_DEPTH)+1 bits wide.
- sdram_q_valid_i outside WAIT_RD is ignored.
- Reset asserted mid-operation: immediate return to IDLE.
  - Queue contents and the pending read are discarded.
  - Any in-flight SDRAM data is ignored after reset releases.

Decomposition:
- Shared package sdram_arb_pkg:
  - arb_state_t enum (IDLE, CMD_RD, WAIT_RD, CMD_WR);
  - wq_entry_t packed struct {addr, data, byte_en};
  - DEFAULT_WQ_DEPTH constant.
- Sub-module wr_queue: the FIFO plus the parallel address-match output used for the hazard check.

Test Plan:
- Write only: wr_req_i with addr 0x00200, data 0x5A5A5A5A, be 0x2, sdram_ready_i tied 1.
  - Response: sdram_wr_o asserted with those exact values 2 cycles later, one command only, queue empty after.
- Read only: rd_req_i at addr 0x01000; sdram_q_i = 0xDEADBEEF valid 3 cycles after accept.
  - Response: rd_data_o = 0xDEADBEEF with a single rd_valid_o pulse; rd_busy_o clears the same cycle.
- Starvation bound: 2 queued writes plus back-to-back reads (each new rd_req_i issued right after rd_valid_o).
  - Response: exactly 3 read commands, then a write command.
- Hazard: queue a write to 0x00400, then rd_req_i to 0x00400 before it drains.
  - Response: the write command precedes the read command.
- Overflow: 5 writes with sdram_ready_i held 0 (WQ_DEPTH = 4).
  - Response: wq_full_o after the 4th; wq_overflow_o sets on the 5th. After ready rises, exactly 4 writes issue in FIFO order.
- Reset mid-read: assert system_reset_n low in WAIT_RD, then release.
  - Response: outputs 0; a late sdram_q_valid_i produces no rd_valid_o.
